eq_coeff_loader: RTL and testbench
==================================

# eq_coeff_loader

Streams a host-supplied gain table into the frequency-domain equalizer's coefficient RAM. The block accepts packed 32-bit words over a valid/ready handshake and unpacks each word into four 8-bit unsigned coefficients (Q3.5; 0x20 = unity). It then drives the equalizer's `coeff_wr_en` / `coeff_index` / `coeff_in` write port at one coefficient per cycle. It sits directly upstream of the equalizer, between the host command/DMA interface and the coefficient store.

## Interface
- `SAMPLES`, 2048: number of FFT bins / coefficient entries; power of two.
- `COEFF_BITS`, 8: coefficient width.
- `WORD_BITS`, 32: host word width; `LANES = WORD_BITS/COEFF_BITS` (derived, 4).
- `IDX_W`, `$clog2(SAMPLES)`: index width (derived).

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle load request; sampled only in IDLE.
- `abort` in 1: cancels an in-progress load.
- `base_index` in IDX_W: first bin to write; latched on start.
- `count` in IDX_W+1: number of coefficients, legal range 1..SAMPLES; latched on start.
- `word_in` in WORD_BITS: packed coefficients, lane 0 = bits [7:0].
- `word_valid` in 1: `word_in` valid.
- `word_ready` out 1: block can accept a word.
- `coeff_wr_en` out 1: write strobe to the equalizer.
- `coeff_index` out IDX_W: bin being written.
- `coeff_in` out COEFF_BITS: coefficient value.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of load, including the error-terminated case.
- `error` out 1: sticky; set on an illegal `count`, cleared on the next accepted start.

## Operation
- States: IDLE, ACCEPT, UNPACK, FINISH.
- **IDLE**
  - On `start`, latch `base_index`, `count`, and set `remaining = count`.
  - If `count == 0` or `count > SAMPLES`: set `error` and go to FINISH; no writes occur.
  - Otherwise clear `error` and go to ACCEPT.
- **ACCEPT**
  - `word_ready = 1`.
  - On `word_valid & word_ready`: load the word into the unpack register, set `lane = 0`, go to UNPACK.
- **UNPACK**
  - Each cycle, drive a write with `coeff_in = byte[lane]` and `coeff_index = (base_index + written) mod SAMPLES`.
  - After each write: `remaining` decrements and `lane` increments.
  - If `remaining` reaches 0 on this cycle: go to FINISH. Leftover lanes of the final word are discarded.
  - Else if `lane == LANES-1`:
    - `word_ready = 1` this cycle.
    - If a word is accepted, reload it and set `lane = 0`, staying in UNPACK.
    - Otherwise go to ACCEPT.
- **FINISH**
  - `done = 1` for one cycle, then go to IDLE.
- Index arithmetic wraps modulo SAMPLES. Example: base 2046, count 4 writes bins 2046, 2047, 0, 1.
- `start` while `busy` is ignored.
- **abort**
  - Forces IDLE on the next edge from any state.
  - `coeff_wr_en` is low from that edge onward.
  - No `done` pulse; `error` is unchanged; any word in flight is dropped.
  - `abort` has priority over `start`, over word acceptance and over the FINISH exit.
- `word_ready` is combinational from state/lane/remaining only, never from `word_valid`.
- Coefficients are passed through unmodified; no saturation or scaling.

## Timing
- Reset values: `word_ready = 0`, `coeff_wr_en = 0`, `coeff_index = 0`, `coeff_in = 0`, `busy = 0`, `done = 0`, `error = 0`; state IDLE.
- `coeff_wr_en`, `coeff_index` and `coeff_in` are registered outputs.
- Start at edge S: ACCEPT from S+1, so `word_ready` is high in cycle S+1.
- Word accepted at edge A: writes for lanes 0..3 appear in cycles A+1..A+4.
- With `word_valid` held high, sustained throughput is one coefficient per cycle with no bubble between words.
- Latency from the last write cycle to the `done` pulse: 1 cycle.
- Full load (count 2048, no backpressure): 2048 consecutive write cycles.
- Illegal count: `done` and `error` rise together at edge S+1 and `busy` is high for exactly one cycle.
- Reset mid-load: outputs return to their reset values immediately (asynchronously). The partially written table is not restored.

## Structure
- Shared package `eq_pkg`, also used by the equalizer:
  - `EQ_SAMPLES`, `EQ_COEFF_BITS = 8`, `EQ_COEFF_FRAC_BITS = 5`.
  - `EQ_UNITY = 8'h20`.
  - `eq_idx_t` typedef.
  - Loader state enum `eq_ld_state_e`.
- Single module; no sub-module is warranted. The lane mux and index counter stay inline.

## Test plan
- **Full load:** base 0, count 2048, words 0x03020100, 0x07060504, … with valid always high → 2048 back-to-back writes with `coeff_in[i] = i & 0xFF`, `done` one cycle after index 2047, `error = 0`.
- **Wrap and partial word:** base 2046, count 6, words 0x44332211, 0x88776655 → writes (2046, 0x11), (2047, 0x22), (0, 0x33), (1, 0x44), (2, 0x55), (3, 0x66); bytes 0x77/0x88 discarded; `done` asserts.
- **Backpressure gaps:** count 8, `word_valid` low for 3 cycles between the two words → write gap of exactly 3 cycles; data and indices are identical to the no-gap case.
- **Illegal count:** `count` 0, and separately 2049 → no `coeff_wr_en`, `done` and `error` high at S+1; a following legal start clears `error`.
- **Abort:** `abort` after the 5th write of a 16-coefficient load → no further writes, no `done`, `busy` low next cycle; a new start then works normally.
- **Reset mid-load:** `rst_n` low during UNPACK → all outputs 0 asynchronously; after release, `start` is sampled normally.

Source files
------------

// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_pkg
// Brief    : Shared constants and types for the frequency-domain equalizer
//            and its coefficient loader.
// Revision : 1.0 - initial release
// ============================================================================
package eq_pkg;

   // Number of FFT bins / coefficient entries (power of two)
   localparam int EQ_SAMPLES         = 2048;
   localparam int EQ_IDX_W           = $clog2(EQ_SAMPLES);

   // Coefficients are unsigned Q3.5: 0x20 is a gain of exactly 1.0
   localparam int EQ_COEFF_BITS      = 8;
   localparam int EQ_COEFF_FRAC_BITS = 5;
   localparam logic [EQ_COEFF_BITS-1:0] EQ_UNITY = 8'h20;

   typedef logic [EQ_IDX_W-1:0] eq_idx_t;

   // Coefficient loader control states
   typedef enum logic [1:0] {
      LD_IDLE   = 2'd0,
      LD_ACCEPT = 2'd1,
      LD_UNPACK = 2'd2,
      LD_FINISH = 2'd3
   } eq_ld_state_e;

endpackage : eq_pkg
`default_nettype wire

// File: rtl/eq_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : eq_coeff_loader
// Brief    : Accepts packed host words over valid/ready and streams the
//            unpacked coefficients into the equalizer coefficient RAM, one
//            coefficient per cycle, starting at a wrapping base index.
// Revision : 1.0 - initial release
// ============================================================================
module eq_coeff_loader
   import eq_pkg::*;
#(
   parameter int SAMPLES    = EQ_SAMPLES,
   parameter int COEFF_BITS = EQ_COEFF_BITS,
   parameter int WORD_BITS  = 32,
   parameter int IDX_W      = $clog2(SAMPLES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [IDX_W-1:0]      base_index,
   input  logic [IDX_W:0]        count,
   input  logic [WORD_BITS-1:0]  word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  coeff_wr_en,
   output logic [IDX_W-1:0]      coeff_index,
   output logic [COEFF_BITS-1:0] coeff_in,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int LANES  = WORD_BITS / COEFF_BITS;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [IDX_W:0]    MAX_COUNT = (IDX_W + 1)'(SAMPLES);

   eq_ld_state_e          state;
   logic [WORD_BITS-1:0]  word_q;      // word currently being unpacked
   logic [LANE_W-1:0]     lane;        // lane whose write is on the outputs
   logic [IDX_W:0]        remaining;   // coefficients not yet issued
   logic [IDX_W-1:0]      next_idx;    // bin for the next issued write

   logic                  take;
   logic                  illegal_count;
   logic [LANE_W-1:0]     lane_nxt;
   logic [COEFF_BITS-1:0] issue_byte;

   // Ready depends only on state/lane/remaining so the host can never
   // create a combinational loop through word_valid.
   assign word_ready = (state == LD_ACCEPT) ||
                       ((state == LD_UNPACK) && (lane == LAST_LANE) && (remaining != '0));
   assign take          = word_valid && word_ready;
   assign busy          = (state != LD_IDLE);
   assign done          = (state == LD_FINISH);
   assign illegal_count = (count == '0) || (count > MAX_COUNT);

   // Outputs lead the state by one edge: the byte for the next write is
   // selected here so it is already registered in the cycle it belongs to.
   // A freshly accepted word always starts at lane 0 of word_in.
   assign lane_nxt   = lane + 1'b1;
   assign issue_byte = ((state == LD_UNPACK) && (lane != LAST_LANE))
                     ? word_q[lane_nxt*COEFF_BITS +: COEFF_BITS]
                     : word_in[COEFF_BITS-1:0];

   // Load sequencer with registered write-port outputs; abort overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= LD_IDLE;
         word_q      <= '0;
         lane        <= '0;
         remaining   <= '0;
         next_idx    <= '0;
         coeff_wr_en <= 1'b0;
         coeff_index <= '0;
         coeff_in    <= '0;
         error       <= 1'b0;
      end else if (abort) begin
         state       <= LD_IDLE;
         coeff_wr_en <= 1'b0;
      end else begin
         coeff_wr_en <= 1'b0;
         case (state)
            LD_IDLE: begin
               if (start) begin
                  next_idx  <= base_index;
                  remaining <= count;
                  if (illegal_count) begin
                     error <= 1'b1;
                     state <= LD_FINISH;
                  end else begin
                     error <= 1'b0;
                     state <= LD_ACCEPT;
                  end
               end
            end
            LD_ACCEPT: begin
               if (take) begin
                  word_q      <= word_in;
                  lane        <= '0;
                  state       <= LD_UNPACK;
                  coeff_wr_en <= 1'b1;
                  coeff_index <= next_idx;
                  coeff_in    <= issue_byte;
                  next_idx    <= next_idx + 1'b1;
                  remaining   <= remaining - 1'b1;
               end
            end
            LD_UNPACK: begin
               if (remaining == '0) begin
                  // Last coefficient is on the outputs now; unused lanes drop.
                  state <= LD_FINISH;
               end else if (lane == LAST_LANE) begin
                  if (take) begin
                     word_q      <= word_in;
                     lane        <= '0;
                     coeff_wr_en <= 1'b1;
                     coeff_index <= next_idx;
                     coeff_in    <= issue_byte;
                     next_idx    <= next_idx + 1'b1;
                     remaining   <= remaining - 1'b1;
                  end else begin
                     state <= LD_ACCEPT;
                  end
               end else begin
                  lane        <= lane_nxt;
                  coeff_wr_en <= 1'b1;
                  coeff_index <= next_idx;
                  coeff_in    <= issue_byte;
                  next_idx    <= next_idx + 1'b1;
                  remaining   <= remaining - 1'b1;
               end
            end
            LD_FINISH: begin
               state <= LD_IDLE;
            end
            default: begin
               state <= LD_IDLE;
            end
         endcase
      end
   end

endmodule : eq_coeff_loader
`default_nettype wire

// File: tb/tb_eq_coeff_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_eq_coeff_loader
// Brief    : Directed self-checking bench for eq_coeff_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eq_coeff_loader;

   localparam int IDX_W = 11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [IDX_W-1:0] base_index = '0;
   logic [IDX_W:0]   count = '0;
   logic [31:0]      word_in = '0;
   logic             word_valid = 1'b0;
   logic             word_ready;
   logic             coeff_wr_en;
   logic [IDX_W-1:0] coeff_index;
   logic [7:0]       coeff_in;
   logic             busy;
   logic             done;
   logic             error;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int wr_cyc[$];
   int wr_idx[$];
   int wr_dat[$];
   int done_cyc[$];
   int exp_i[$];
   int exp_d[$];

   eq_coeff_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .base_index  (base_index),
      .count       (count),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .coeff_wr_en (coeff_wr_en),
      .coeff_index (coeff_index),
      .coeff_in    (coeff_in),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Cycle stamp used to measure gaps and latencies
   always @(posedge clk) cyc <= cyc + 1;

   // Record every write and done pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (coeff_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_idx.push_back(int'(coeff_index));
            wr_dat.push_back(int'(coeff_in));
         end
         if (done) done_cyc.push_back(cyc);
      end
   end

   // Hard stop in case something never completes
   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_cyc.delete();
      wr_idx.delete();
      wr_dat.delete();
      done_cyc.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 just after the start edge
   task automatic do_start(input int b, input int c);
      base_index = IDX_W'(b);
      count      = (IDX_W + 1)'(c);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // Presents one word and returns at posedge+1 after the accepting edge
   task automatic push_word(input logic [31:0] w);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      word_in    = w;
      word_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = word_ready;
         @(posedge clk); #1;
         n++;
      end
      check("word_accept", {31'b0, acc}, 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cyc.size() == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", {31'b0, done_cyc.size() != 0}, 32'd1);
   endtask

   task automatic check_writes(input string tag, input int ei[$], input int ed[$]);
      check({tag, "_nwr"}, wr_idx.size(), ei.size());
      for (int i = 0; i < ei.size() && i < wr_idx.size(); i++) begin
         check({tag, "_idx"}, wr_idx[i], ei[i]);
         check({tag, "_dat"}, wr_dat[i], ed[i]);
      end
   endtask

   function automatic int last_wr();
      return (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -100;
   endfunction

   initial begin
      int bad;
      logic [31:0] w;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", word_ready, 0);
      check("rst_wr_en", coeff_wr_en, 0);
      check("rst_index", coeff_index, 0);
      check("rst_coeff", coeff_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---------------- full load, back to back ----------------
      clear_log();
      do_start(0, 2048);
      check("full_ready_s1", word_ready, 1);
      check("full_busy", busy, 1);
      for (int k = 0; k < 512; k++) begin
         w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
         push_word(w);
      end
      word_valid = 1'b0;
      wait_done(20);
      check("full_nwr", wr_idx.size(), 2048);
      bad = 0;
      for (int i = 0; i < wr_idx.size(); i++) begin
         if (wr_idx[i] != i) bad++;
         if (wr_dat[i] != (i & 255)) bad++;
         if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) bad++;
      end
      check("full_bad_entries", bad, 0);
      check("full_done_lat", (done_cyc.size() > 0) ? done_cyc[0] : -1, last_wr() + 1);
      check("full_ndone", done_cyc.size(), 1);
      check("full_error", error, 0);

      // ---------------- wrap and partial final word ----------------
      clear_log();
      do_start(2046, 6);
      push_word(32'h44332211);
      push_word(32'h88776655);
      word_valid = 1'b0;
      wait_done(20);
      exp_i = '{2046, 2047, 0, 1, 2, 3};
      exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
      check_writes("wrap", exp_i, exp_d);
      check("wrap_span", last_wr() - ((wr_cyc.size() > 0) ? wr_cyc[0] : 0), 5);
      check("wrap_done_lat", (done_cyc.size() > 0) ? done_cyc[0] : -1, last_wr() + 1);
      repeat (4) @(posedge clk);
      #1;
      check("wrap_nwr_after", wr_idx.size(), 6);

      // ---------------- backpressure gap ----------------
      clear_log();
      do_start(100, 8);
      push_word(32'h44332211);
      word_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      push_word(32'h88776655);
      word_valid = 1'b0;
      wait_done(30);
      exp_i = '{100, 101, 102, 103, 104, 105, 106, 107};
      exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
      check_writes("bp", exp_i, exp_d);
      if (wr_cyc.size() == 8) begin
         check("bp_first_span", wr_cyc[3] - wr_cyc[0], 3);
         check("bp_gap", wr_cyc[4] - wr_cyc[3], 4);
         check("bp_second_span", wr_cyc[7] - wr_cyc[4], 3);
      end else begin
         check("bp_stamps", wr_cyc.size(), 8);
      end

      // ---------------- illegal count 0 ----------------
      clear_log();
      do_start(0, 0);
      @(negedge clk);
      check("ill0_done", done, 1);
      check("ill0_error", error, 1);
      check("ill0_busy", busy, 1);
      check("ill0_ready", word_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ill0_busy_end", busy, 0);
      check("ill0_done_end", done, 0);
      check("ill0_error_sticky", error, 1);
      @(posedge clk); #1;
      check("ill0_nwr", wr_idx.size(), 0);

      // ---------------- illegal count 2049 ----------------
      clear_log();
      do_start(7, 2049);
      @(negedge clk);
      check("ill_big_done", done, 1);
      check("ill_big_error", error, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("ill_big_busy_end", busy, 0);
      @(posedge clk); #1;
      check("ill_big_nwr", wr_idx.size(), 0);

      // ---------------- legal start clears error ----------------
      clear_log();
      do_start(5, 1);
      check("legal_error_clr", error, 0);
      push_word(32'hAABBCCDD);
      word_valid = 1'b0;
      wait_done(20);
      exp_i = '{5};
      exp_d = '{32'hDD};
      check_writes("one", exp_i, exp_d);

      // ---------------- abort after 5th write ----------------
      clear_log();
      do_start(0, 16);
      push_word(32'h03020100);
      push_word(32'h07060504);
      abort = 1'b1;
      @(posedge clk); #1;
      abort      = 1'b0;
      word_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_wr_en", coeff_wr_en, 0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_nwr", wr_idx.size(), 5);
      check("abort_ndone", done_cyc.size(), 0);
      check("abort_error", error, 0);
      clear_log();
      do_start(10, 2);
      push_word(32'h0000BEEF);
      word_valid = 1'b0;
      wait_done(20);
      exp_i = '{10, 11};
      exp_d = '{32'hEF, 32'hBE};
      check_writes("post_abort", exp_i, exp_d);

      // ---------------- reset mid-load ----------------
      clear_log();
      do_start(200, 8);
      push_word(32'h44332211);
      #3;
      rst_n = 1'b0;
      #1;
      check("mrst_wr_en", coeff_wr_en, 0);
      check("mrst_index", coeff_index, 0);
      check("mrst_coeff", coeff_in, 0);
      check("mrst_busy", busy, 0);
      check("mrst_ready", word_ready, 0);
      check("mrst_done", done, 0);
      word_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_log();
      do_start(3, 1);
      check("mrst_restart_ready", word_ready, 1);
      push_word(32'h000000A5);
      word_valid = 1'b0;
      wait_done(20);
      exp_i = '{3};
      exp_d = '{32'hA5};
      check_writes("mrst", exp_i, exp_d);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_eq_coeff_loader
`default_nettype wire
